// File: rtl/axi_ad9234_pack.sv
// AD9234 two-channel sample packer feeding a first-word-fall-through DMA FIFO.
// Optional macro AD9234_PACK_SYNC_EN adds adc_sync_in to align capture start to a trigger.
module axi_ad9234_pack #(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       adc_clk,
    input  logic                       adc_rst,
`ifdef AD9234_PACK_SYNC_EN
    input  logic                       adc_sync_in,
`endif
    input  logic                       adc_enable_0,
    input  logic                       adc_valid_0,
    input  logic [63:0]                adc_data_0,
    input  logic                       adc_enable_1,
    input  logic                       adc_valid_1,
    input  logic [63:0]                adc_data_1,
    input  logic                       dma_xfer_req,
    input  logic                       dma_ready,
    output logic                       dma_wr,
    output logic [127:0]               dma_data,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       adc_dovf
);

    localparam int                       DEPTH   = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] LVL_MAX = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] LVL_ONE = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2:0] LVL_NIL = (FIFO_DEPTH_LOG2 + 1)'(0);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = (FIFO_DEPTH_LOG2)'(1);

    // Sample-interleave two 4-sample beats, ch0 sample first at each position.
    function automatic logic [127:0] interleave(input logic [63:0] c0, input logic [63:0] c1);
        logic [127:0] w;
        w = 128'd0;
        for (int i = 0; i < 4; i++) begin
            w[32*i +: 16]      = c0[16*i +: 16];
            w[32*i + 16 +: 16] = c1[16*i +: 16];
        end
        return w;
    endfunction

    logic                       active_r;
    logic                       req_r;
    logic [1:0]                 mask_r;
    logic                       phase_r;
    logic [63:0]                half_r;
    logic [127:0]               word_r;
    logic                       word_vld_r;
    logic [127:0]               mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_r;

    logic [1:0]                 mask_s;
    logic                       active_s;
    logic                       accept_s;
    logic                       phase_eff_s;
    logic                       single_s;
    logic [63:0]                beat_s;
    logic                       pop_s;
    logic                       full_s;
    logic                       push_s;
    logic                       drop_s;
    logic                       bypass_s;
    logic [FIFO_DEPTH_LOG2:0]   level_nxt_s;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_nxt_s;

    // Beat acceptance, phase resolution and FIFO handshake decode.
    always_comb begin
        mask_s = {adc_enable_1, adc_enable_0};
`ifdef AD9234_PACK_SYNC_EN
        active_s = dma_xfer_req && (active_r || adc_sync_in);
`else
        active_s = active_r;
`endif
        accept_s = active_s && (mask_s != 2'b00) &&
                   (adc_valid_0 || !adc_enable_0) && (adc_valid_1 || !adc_enable_1);
        single_s = (mask_s == 2'b01) || (mask_s == 2'b10);
        if (mask_s == mask_r) begin
            phase_eff_s = phase_r;
        end else begin
            phase_eff_s = 1'b0;
        end
        if (adc_enable_0) begin
            beat_s = adc_data_0;
        end else begin
            beat_s = adc_data_1;
        end
        pop_s  = dma_wr && dma_ready;
        full_s = (fifo_level == LVL_MAX);
        push_s = word_vld_r && (!full_s || pop_s);
        drop_s = word_vld_r && full_s && !pop_s;
        level_nxt_s = fifo_level + (push_s ? LVL_ONE : LVL_NIL) - (pop_s ? LVL_ONE : LVL_NIL);
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // The new word is the head when nothing else survives this cycle's pop.
        bypass_s = push_s && ((fifo_level == LVL_NIL) || ((fifo_level == LVL_ONE) && pop_s));
    end

    // Capture control and word assembly stage.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            active_r   <= 1'b0;
            req_r      <= 1'b0;
            mask_r     <= 2'b00;
            phase_r    <= 1'b0;
            half_r     <= 64'd0;
            word_r     <= 128'd0;
            word_vld_r <= 1'b0;
        end else begin
`ifdef AD9234_PACK_SYNC_EN
            active_r <= active_s;
`else
            active_r <= dma_xfer_req;
`endif
            req_r      <= dma_xfer_req;
            mask_r     <= mask_s;
            word_vld_r <= 1'b0;
            if (accept_s) begin
                if (mask_s == 2'b11) begin
                    word_r     <= interleave(adc_data_0, adc_data_1);
                    word_vld_r <= 1'b1;
                    phase_r    <= 1'b0;
                end else if (phase_eff_s) begin
                    word_r     <= {beat_s, half_r};
                    word_vld_r <= 1'b1;
                    phase_r    <= 1'b0;
                end else begin
                    half_r  <= beat_s;
                    phase_r <= 1'b1;
                end
            end else if (!active_s || !single_s || (mask_s != mask_r)) begin
                phase_r <= 1'b0;
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    // FIFO storage array; contents need no reset since pointers gate every read.
    always_ff @(posedge adc_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_r;
        end
    end

    // FIFO pointers, level, registered head word and sticky overflow.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_level <= '0;
            dma_wr     <= 1'b0;
            dma_data   <= 128'd0;
            adc_dovf   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            fifo_level <= level_nxt_s;
            dma_wr     <= (level_nxt_s != LVL_NIL);
            if (bypass_s) begin
                dma_data <= word_r;
            end else if (level_nxt_s != LVL_NIL) begin
                dma_data <= mem_r[rd_ptr_nxt_s];
            end else begin
                dma_data <= dma_data;
            end
            if (drop_s) begin
                adc_dovf <= 1'b1;
            end else if (dma_xfer_req && !req_r) begin
                adc_dovf <= 1'b0;
            end else begin
                adc_dovf <= adc_dovf;
            end
        end
    end

endmodule

// File: tb/tb_axi_ad9234_pack.sv
// Scoreboard bench for axi_ad9234_pack: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_axi_ad9234_pack;

    localparam int LOG2 = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sync_in = 1'b1;
    logic           en0 = 1'b0, v0 = 1'b0, en1 = 1'b0, v1 = 1'b0;
    logic [63:0]    d0 = 64'd0, d1 = 64'd0;
    logic           req = 1'b0, rdy = 1'b0;
    logic           dma_wr;
    logic [127:0]   dma_data;
    logic [LOG2:0]  fifo_level;
    logic           adc_dovf;

    logic [127:0]   exp_q[$];
    logic [127:0]   exp_w;
    int             checks = 0;
    int             passes = 0;
    int             hi;
    logic [15:0]    a16, b16;

    axi_ad9234_pack #(.FIFO_DEPTH_LOG2(LOG2)) dut (
        .adc_clk      (clk),
        .adc_rst      (rst),
`ifdef AD9234_PACK_SYNC_EN
        .adc_sync_in  (sync_in),
`endif
        .adc_enable_0 (en0),
        .adc_valid_0  (v0),
        .adc_data_0   (d0),
        .adc_enable_1 (en1),
        .adc_valid_1  (v1),
        .adc_data_1   (d1),
        .dma_xfer_req (req),
        .dma_ready    (rdy),
        .dma_wr       (dma_wr),
        .dma_data     (dma_data),
        .fifo_level   (fifo_level),
        .adc_dovf     (adc_dovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // Monitor: every DMA acceptance is compared to the scoreboard head.
    always @(negedge clk) begin
        if (!rst && dma_wr && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %h expected none", dma_data);
            end else begin
                exp_w = exp_q.pop_front();
                chk("word", dma_data, exp_w);
            end
        end
    end

    initial begin
        step(); step();
        @(negedge clk);
        chk("rst_dma_wr", 128'(dma_wr), 128'd0);
        chk("rst_level", 128'(fifo_level), 128'd0);
        chk("rst_dovf", 128'(adc_dovf), 128'd0);
        chk("rst_data", dma_data, 128'd0);
        step();
        rst = 1'b0;

        // DUAL: one beat, latency and layout
        req = 1'b1; en0 = 1'b1; en1 = 1'b1; rdy = 1'b1;
        step();
        v0 = 1'b1; v1 = 1'b1;
        d0 = 64'h0003_0002_0001_0000; d1 = 64'h0013_0012_0011_0010;
        exp_q.push_back(128'h0013_0003_0012_0002_0011_0001_0010_0000);
        step();
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk) chk("dual_t1_wr", 128'(dma_wr), 128'd0);
        step();
        @(negedge clk) chk("dual_t2_wr", 128'(dma_wr), 128'd1);
        step();
        @(negedge clk) chk("dual_level_back0", 128'(fifo_level), 128'd0);

        // SINGLE on ch1: A then B make {B,A}; a lone C is discarded on disable
        en0 = 1'b0;
        step();
        v1 = 1'b1; d1 = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        d1 = 64'hBBBB_BBBB_BBBB_BBBB;
        exp_q.push_back(128'hBBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_AAAA);
        step();
        v1 = 1'b0;
        drain();
        v1 = 1'b1; d1 = 64'hCCCC_CCCC_CCCC_CCCC;
        step();
        v1 = 1'b0; en1 = 1'b0;
        hi = 0;
        repeat (6) begin
            @(negedge clk) if (dma_wr) hi++;
            step();
        end
        chk("single_c_discarded", 128'(hi), 128'd0);

        // Overflow: depth 4, six DUAL beats with DMA stalled
        rdy = 1'b0; en0 = 1'b1; en1 = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            a16 = 16'(i); b16 = 16'(16'h0100 + i);
            d0 = {a16, a16, a16, a16}; d1 = {b16, b16, b16, b16};
            v0 = 1'b1; v1 = 1'b1;
            if (i < 4) exp_q.push_back({b16, a16, b16, a16, b16, a16, b16, a16});
            step();
            if (i == 4) begin
                @(negedge clk);
                chk("ovf_level_full", 128'(fifo_level), 128'd4);
                chk("ovf_dovf_before", 128'(adc_dovf), 128'd0);
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("ovf_dovf_set", 128'(adc_dovf), 128'd1);
        chk("ovf_level_held", 128'(fifo_level), 128'd4);
        step(); step();
        @(negedge clk) chk("ovf_dovf_sticky", 128'(adc_dovf), 128'd1);
        req = 1'b0;
        step();
        req = 1'b1;
        step();
        @(negedge clk);
        chk("req_rise_dovf_clr", 128'(adc_dovf), 128'd0);
        chk("req_rise_level", 128'(fifo_level), 128'd4);
        chk("req_rise_head", dma_data, 128'h0100_0000_0100_0000_0100_0000_0100_0000);

        // Full FIFO: push coincides with a pop
        a16 = 16'h0006; b16 = 16'h0106;
        d0 = {a16, a16, a16, a16}; d1 = {b16, b16, b16, b16};
        v0 = 1'b1; v1 = 1'b1;
        exp_q.push_back({b16, a16, b16, a16, b16, a16, b16, a16});
        step();
        v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
        step();
        rdy = 1'b0;
        @(negedge clk);
        chk("full_pop_push_level", 128'(fifo_level), 128'd4);
        chk("full_pop_push_dovf", 128'(adc_dovf), 128'd0);
        rdy = 1'b1;
        drain();
        @(negedge clk) chk("full_drained_level", 128'(fifo_level), 128'd0);

        // Reset mid-capture with level 3 and a stored half-word
        rdy = 1'b0;
        d0 = 64'h5555_5555_5555_5555; d1 = 64'h6666_6666_6666_6666;
        v0 = 1'b1; v1 = 1'b1;
        repeat (3) step();
        v0 = 1'b0; v1 = 1'b0; en1 = 1'b0;
        step();
        v0 = 1'b1; d0 = 64'h7777_7777_7777_7777;
        step();
        v0 = 1'b0;
        step(); step();
        @(negedge clk) chk("pre_rst_level", 128'(fifo_level), 128'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_dma_wr", 128'(dma_wr), 128'd0);
        chk("mid_rst_level", 128'(fifo_level), 128'd0);
        chk("mid_rst_dovf", 128'(adc_dovf), 128'd0);
        step();
        v0 = 1'b1; d0 = 64'h1111_1111_1111_1111;
        step();
        d0 = 64'h2222_2222_2222_2222;
        exp_q.push_back(128'h2222_2222_2222_2222_1111_1111_1111_1111);
        step();
        v0 = 1'b0; rdy = 1'b1;
        drain();

`ifdef AD9234_PACK_SYNC_EN
        // Sync: no words until the trigger cycle, then a 2-cycle latency
        en1 = 1'b1; req = 1'b0;
        step();
        sync_in = 1'b0; req = 1'b1;
        v0 = 1'b1; v1 = 1'b1; d0 = {4{16'hDEAD}}; d1 = {4{16'hBEEF}};
        hi = 0;
        repeat (10) begin
            @(negedge clk) if (dma_wr) hi++;
            step();
        end
        sync_in = 1'b1;
        d0 = 64'h0003_0002_0001_0000; d1 = 64'h0013_0012_0011_0010;
        exp_q.push_back(128'h0013_0003_0012_0002_0011_0001_0010_0000);
        @(negedge clk) if (dma_wr) hi++;
        step();
        sync_in = 1'b0; v0 = 1'b0; v1 = 1'b0;
        @(negedge clk) if (dma_wr) hi++;
        chk("sync_no_early_words", 128'(hi), 128'd0);
        step();
        @(negedge clk) chk("sync_t2_wr", 128'(dma_wr), 128'd1);
        step();
`endif

        step();
        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
